handshake_constant_arbiter: RTL and testbench
=============================================

Name: handshake_constant_arbiter

Overview:
- Round-robin arbiter that shares one constant-source unit among NUM_REQ elastic control requesters in the dataflow circuit.
- Each accepted ctrl token produces one output token carrying CONST_VALUE plus the index of the winning requester.
- The output is registered in a one-slot opaque buffer: latency 1 cycle, full throughput of 1 token/cycle.

Parameters:
- NUM_REQ, 4, number of ctrl requesters; legal range 2..16.
- DATA_WIDTH, 32, width of outs.
- CONST_VALUE, 32'hFFFFFFFF, constant driven on outs; truncated to DATA_WIDTH.
- IDX_WIDTH, localparam = max(1, ceil(log2(NUM_REQ))), width of index.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-low reset (0 = reset).
- ins_valid  input  NUM_REQ  per-requester ctrl valid; bit i belongs to requester i.
- ins_ready  output  NUM_REQ  per-requester ctrl ready; at most one bit high per cycle.
- outs  output  DATA_WIDTH  constant data of the buffered token.
- index  output  IDX_WIDTH  requester number that produced the buffered token.
- outs_valid  output  1  output slot holds a token.
- outs_ready  input  1  downstream accepts the token.

Behaviour:
- State:
  - full: 1 bit, output slot occupied.
  - idx_q: IDX_WIDTH bits, index of the buffered token.
  - ptr: IDX_WIDTH bits, round-robin priority pointer.
- Reset (sampled on posedge clk while rst==0): full=0, idx_q=0, ptr=0. Therefore outs_valid=0 and index=0 in the cycle after reset.
- Any token in flight is discarded on reset. ins_ready is forced to 0 during every cycle rst==0.
- outs = CONST_VALUE at all times, independent of full. outs_valid = full. index = idx_q.
- can_accept = !full || outs_ready. Pass-through is allowed: a full slot that is drained this cycle may be refilled in the same cycle.
- Grant: the first i with ins_valid[i]==1, searching ptr, ptr+1, ... wrapping mod NUM_REQ. grant_any = at least one ins_valid bit set.
- ins_ready[g] = can_accept && grant_any for the granted g only; all other bits are 0. Grant is purely combinational on ins_valid and ptr; there is no combinational path from outs_ready to the grant choice.
- On accept (ins_valid[g] && ins_ready[g]):
  - full <= 1
  - idx_q <= g
  - ptr <= (g+1) mod NUM_REQ (wraps from NUM_REQ-1 to 0)
- No accept and outs_ready && full: full <= 0; idx_q and ptr hold.
- No accept and no drain: all state holds.
- Simultaneous drain and accept: full stays 1 and idx_q takes the new g. No bubble and no duplicated token.
- Stalled output (full && !outs_ready): all ins_ready = 0, ptr frozen. A requester whose valid stays asserted keeps its priority.
- Requesters must keep ins_valid asserted until their ready is seen. If a requester drops valid without a handshake, the grant recomputes on the next cycle; this is not an error.
- Fairness: with all requesters continuously valid and outs_ready=1, grants rotate 0,1,..,NUM_REQ-1,0,... Each requester waits at most NUM_REQ-1 grants.
- Valid tokens are never dropped and never duplicated.

Optional Feature:
- Macro: HANDSHAKE_CONSTANT_ARBITER_STATS_EN.
- Defined:
  - Adds output port grant_count, 16 bits.
  - grant_count is a saturating count of accepted tokens: reset to 0, +1 per accept, holds at 16'hFFFF.
  - Adds output port stall_count, 16 bits: saturating count of cycles with full && !outs_ready.
- Undefined: neither port nor counter exists; the behaviour of all other ports is identical.

Test Plan:
- Reset: hold rst=0 for 3 cycles with all ins_valid=1 -> ins_ready=0000, outs_valid=0, index=0. After release, first accept grants requester 0.
- Round robin: NUM_REQ=4, ins_valid=1111 held, outs_ready=1 -> one token per cycle. index sequence 0,1,2,3,0,1; outs=32'hFFFFFFFF on every token.
- Skip idle requesters: ins_valid=1010, ptr=0 -> grants 1,3,1,3; requesters 0 and 2 are never readied.
- Backpressure: fill the slot with requester 2, then outs_ready=0 for 5 cycles with ins_valid=1111 -> outs_valid=1 and index=2 held, ins_ready=0000, ptr=3. On release, the drain and the accept of requester 3 happen in the same cycle.
- Mid-operation reset: token buffered with index=1, assert rst=0 for 1 cycle -> outs_valid=0 next cycle, ptr=0, and the token is lost.
- Stats (macro defined): 70000 accepts with outs_ready=1 -> grant_count saturates at 65535. 4 stall cycles -> stall_count=4.

Source files
------------

// File: rtl/handshake_constant_arbiter.sv
// Round-robin arbiter sharing one constant source among NUM_REQ ctrl requesters, with a one-slot output buffer.
// Optional grant/stall counters are enabled by defining HANDSHAKE_CONSTANT_ARBITER_STATS_EN.
module handshake_constant_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] CONST_VALUE = DATA_WIDTH'(32'hFFFFFFFF),
    localparam int IDX_WIDTH = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    ins_valid,
    output logic [NUM_REQ-1:0]    ins_ready,
    output logic [DATA_WIDTH-1:0] outs,
    output logic [IDX_WIDTH-1:0]  index,
    output logic                  outs_valid,
    input  logic                  outs_ready
`ifdef HANDSHAKE_CONSTANT_ARBITER_STATS_EN
    ,
    output logic [15:0]           grant_count,
    output logic [15:0]           stall_count
`endif
);

    logic                   full;
    logic [IDX_WIDTH-1:0]   idx_q;
    logic [IDX_WIDTH-1:0]   ptr;
    logic [IDX_WIDTH-1:0]   grant_idx;
    logic [IDX_WIDTH-1:0]   ptr_next;
    logic [2*NUM_REQ-1:0]   rot2;
    logic [IDX_WIDTH:0]     sum;
    logic                   grant_any;
    logic                   can_accept;
    logic                   accept;

    // Rotate the request vector so bit k is requester (ptr+k); the lowest set k wins.
    always_comb begin
        rot2      = {ins_valid, ins_valid} >> ptr;
        grant_idx = '0;
        sum       = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (rot2[k]) begin
                sum = {1'b0, ptr} + (IDX_WIDTH + 1)'(k);
                if (sum >= (IDX_WIDTH + 1)'(NUM_REQ))
                    sum = sum - (IDX_WIDTH + 1)'(NUM_REQ);
                grant_idx = sum[IDX_WIDTH-1:0];
            end
        end
    end

    assign grant_any  = |ins_valid;
    assign can_accept = !full || outs_ready;
    assign accept     = rst && can_accept && grant_any;
    assign ptr_next   = (grant_idx == IDX_WIDTH'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;

    always_comb begin
        ins_ready = '0;
        if (accept)
            ins_ready[grant_idx] = 1'b1;
    end

    assign outs       = CONST_VALUE;
    assign outs_valid = full;
    assign index      = idx_q;

    // Output slot: an accept always wins, so a drain and refill in one cycle keeps full set.
    always_ff @(posedge clk) begin
        if (!rst) begin
            full  <= 1'b0;
            idx_q <= '0;
            ptr   <= '0;
        end else if (accept) begin
            full  <= 1'b1;
            idx_q <= grant_idx;
            ptr   <= ptr_next;
        end else if (outs_ready) begin
            full  <= 1'b0;
        end
    end

`ifdef HANDSHAKE_CONSTANT_ARBITER_STATS_EN
    logic [15:0] grant_cnt;
    logic [15:0] stall_cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            grant_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            if (accept && grant_cnt != 16'hFFFF)
                grant_cnt <= grant_cnt + 16'd1;
            if (full && !outs_ready && stall_cnt != 16'hFFFF)
                stall_cnt <= stall_cnt + 16'd1;
        end
    end

    assign grant_count = grant_cnt;
    assign stall_count = stall_cnt;
`endif

endmodule

// File: tb/tb_handshake_constant_arbiter.sv
// Directed bench for handshake_constant_arbiter (NUM_REQ=4, DATA_WIDTH=32); stats checks run when
// HANDSHAKE_CONSTANT_ARBITER_STATS_EN is defined.
module tb_handshake_constant_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  ins_valid;
    logic [3:0]  ins_ready;
    logic [31:0] outs;
    logic [1:0]  index;
    logic        outs_valid;
    logic        outs_ready;
`ifdef HANDSHAKE_CONSTANT_ARBITER_STATS_EN
    logic [15:0] grant_count;
    logic [15:0] stall_count;
`endif

    int total = 0;
    int passed = 0;

    always #5 clk = ~clk;

    handshake_constant_arbiter #(
        .NUM_REQ(4),
        .DATA_WIDTH(32),
        .CONST_VALUE(32'hFFFFFFFF)
    ) dut (
        .clk(clk),
        .rst(rst),
        .ins_valid(ins_valid),
        .ins_ready(ins_ready),
        .outs(outs),
        .index(index),
        .outs_valid(outs_valid),
        .outs_ready(outs_ready)
`ifdef HANDSHAKE_CONSTANT_ARBITER_STATS_EN
        ,
        .grant_count(grant_count),
        .stall_count(stall_count)
`endif
    );

    typedef struct {
        logic       rst;
        logic [3:0] iv;
        logic       ordy;
        logic [3:0] exp_ready;
        logic       exp_ov;
        logic [1:0] exp_idx;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp)
            passed++;
        else
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic add(input logic r, input logic [3:0] iv, input logic o,
                       input logic [3:0] er, input logic ov, input logic [1:0] ix);
        vec_t v;
        v.rst = r; v.iv = iv; v.ordy = o; v.exp_ready = er; v.exp_ov = ov; v.exp_idx = ix;
        vecs.push_back(v);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        ins_valid = '0;
        outs_ready = 1'b0;
        step();
        rst = 1'b1;
    endtask

    initial begin
        int exp_g;

        // Reset held with all requesters valid.
        add(0, 4'b1111, 1, 4'b0000, 0, 0);
        add(0, 4'b1111, 1, 4'b0000, 0, 0);
        add(0, 4'b1111, 1, 4'b0000, 0, 0);
        // Round robin with everyone valid: grants 0,1,2,3,0,1.
        add(1, 4'b1111, 1, 4'b0001, 0, 0);
        add(1, 4'b1111, 1, 4'b0010, 1, 0);
        add(1, 4'b1111, 1, 4'b0100, 1, 1);
        add(1, 4'b1111, 1, 4'b1000, 1, 2);
        add(1, 4'b1111, 1, 4'b0001, 1, 3);
        add(1, 4'b1111, 1, 4'b0010, 1, 0);
        // Mid-operation reset with token index 1 buffered: token lost, ptr back to 0.
        add(0, 4'b0000, 0, 4'b0000, 1, 1);
        add(1, 4'b0000, 1, 4'b0000, 0, 0);
        // Idle requesters 0 and 2 skipped: grants 1,3,1,3.
        add(1, 4'b1010, 1, 4'b0010, 0, 0);
        add(1, 4'b1010, 1, 4'b1000, 1, 1);
        add(1, 4'b1010, 1, 4'b0010, 1, 3);
        add(1, 4'b1010, 1, 4'b1000, 1, 1);
        // Fill with requester 2, then stall 5 cycles with all valid.
        add(1, 4'b0100, 1, 4'b0100, 1, 3);
        for (int i = 0; i < 5; i++)
            add(1, 4'b1111, 0, 4'b0000, 1, 2);
        // Release: drain of 2 and accept of 3 in the same cycle.
        add(1, 4'b1111, 1, 4'b1000, 1, 2);
        add(1, 4'b0000, 1, 4'b0000, 1, 3);
        add(1, 4'b0000, 1, 4'b0000, 0, 3);
        // Empty slot accepts even while downstream is not ready, then stalls.
        add(1, 4'b0001, 0, 4'b0001, 0, 3);
        add(1, 4'b0001, 0, 4'b0000, 1, 0);
        add(1, 4'b0000, 1, 4'b0000, 1, 0);
        add(1, 4'b0000, 0, 4'b0000, 0, 0);

        do_reset();
        foreach (vecs[i]) begin
            rst        = vecs[i].rst;
            ins_valid  = vecs[i].iv;
            outs_ready = vecs[i].ordy;
            #1;
            chk($sformatf("v%0d ins_ready", i), 32'(ins_ready), 32'(vecs[i].exp_ready));
            chk($sformatf("v%0d outs_valid", i), 32'(outs_valid), 32'(vecs[i].exp_ov));
            chk($sformatf("v%0d index", i), 32'(index), 32'(vecs[i].exp_idx));
            chk($sformatf("v%0d outs", i), outs, 32'hFFFFFFFF);
            step();
        end

        // Fairness: all valid, outs_ready=1 from a reset pointer, 10 grants rotate.
        do_reset();
        ins_valid = 4'b1111;
        outs_ready = 1'b1;
        exp_g = 0;
        for (int i = 0; i < 10; i++) begin
            #1;
            chk("rr ins_ready", 32'(ins_ready), 32'(4'b0001 << exp_g));
            step();
            chk("rr index", 32'(index), 32'(exp_g));
            chk("rr outs_valid", 32'(outs_valid), 32'd1);
            exp_g = (exp_g + 1) % 4;
        end

        // Valid dropped without handshake under stall: grant recomputes next cycle.
        do_reset();
        ins_valid = 4'b0001;
        outs_ready = 1'b0;
        step();
        ins_valid = 4'b0100;
        #1;
        chk("drop stalled ready", 32'(ins_ready), 32'd0);
        step();
        ins_valid = 4'b1000;
        outs_ready = 1'b1;
        #1;
        chk("drop regrant", 32'(ins_ready), 32'(4'b1000));
        step();
        chk("drop index", 32'(index), 32'd3);

`ifdef HANDSHAKE_CONSTANT_ARBITER_STATS_EN
        do_reset();
        chk("stats grant reset", 32'(grant_count), 32'd0);
        chk("stats stall reset", 32'(stall_count), 32'd0);
        ins_valid = 4'b0001;
        outs_ready = 1'b1;
        for (int i = 0; i < 65534; i++)
            step();
        chk("stats grant 65534", 32'(grant_count), 32'd65534);
        for (int i = 0; i < 70000 - 65534; i++)
            step();
        chk("stats grant sat", 32'(grant_count), 32'd65535);
        chk("stats stall none", 32'(stall_count), 32'd0);
        do_reset();
        ins_valid = 4'b0001;
        outs_ready = 1'b0;
        step();
        ins_valid = 4'b0000;
        for (int i = 0; i < 4; i++)
            step();
        chk("stats stall 4", 32'(stall_count), 32'd4);
        chk("stats grant 1", 32'(grant_count), 32'd1);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
